branch_redirect_ctrl: RTL and testbench

EX-stage controller that sequences the branch target adder's result into the fetch path. It evaluates branch/jump resolution from EX, checks the target's alignment, and issues a held redirect request to the PC unit with a valid/ready handshake. It also flushes the IF/ID and ID/EX registers for the wrong-path window and keeps a saturating count of taken redirects.

---
 rtl/branch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect sequencer: decodes taken branches/jumps, issues a held redirect, flushes wrong path.
// Latency 1 cycle EX decision -> redirect_valid; redirect held (pc stable) until redirect_ready, EX ignored while busy.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  input  logic [XLEN-1:0]  branch_address,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_squash,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] taken_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic flush;
    logic misalign;
  } ctl_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t            ctl_q, ctl_d;

  logic cond;
  logic taken;
  logic aligned;
  logic capture;
  logic handshake;

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = ex_zero;
      3'b001:  cond = ~ex_zero;
      3'b100:  cond = ex_lt;
      3'b101:  cond = ~ex_lt;
      3'b110:  cond = ex_ltu;
      3'b111:  cond = ~ex_ltu;
      default: cond = 1'b0;
    endcase
  end

  // Jump takes priority over branch when both flags are raised.
  assign taken     = ex_valid & (ex_jump | (ex_branch & cond));
  assign aligned   = (branch_address[1:0] == 2'b00);
  assign capture   = (state_q == ST_IDLE) & taken & aligned;
  assign handshake = (state_q == ST_REDIRECT) & redirect_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      ctl_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      ctl_q       <= ctl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
          state_d     = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - FCW'(1);
        if (flush_cnt_q == FCW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values are computed for the next cycle and registered alongside the state.
  always_comb begin
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    ctl_d          = '0;
    if (capture) pc_d = branch_address;
    if (handshake && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    ctl_d.vld      = (state_d == ST_REDIRECT);
    ctl_d.flush    = (state_d != ST_IDLE);
    ctl_d.misalign = (state_q == ST_IDLE) & taken & ~aligned;
  end

  assign redirect_valid = ctl_q.vld;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = ctl_q.flush;
  assign flush_id_ex    = ctl_q.flush;
  assign ex_squash      = ctl_q.flush;
  assign misalign_exc   = ctl_q.misalign;
  assign taken_count    = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized + directed bench for branch_redirect_ctrl: two instances (default, and FLUSH_CYCLES=1/CNT_W=2)
// checked against a transaction-level reference model through an event scoreboard.
module tb_branch_redirect_ctrl;
  localparam int NI = 2;

  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 0, ex_branch = 0, ex_jump = 0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_zero = 0, ex_lt = 0, ex_ltu = 0;
  logic [31:0] branch_address = '0;
  logic        redirect_ready = 0;

  logic [NI-1:0]       rv, fid, fde, sq, mis;
  logic [NI-1:0][31:0] rpc;
  logic [15:0]         cnt0;
  logic [1:0]          cnt1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ev_t q0[$];
  ev_t q1[$];

  // Reference model: busy while a redirect waits or flush cycles remain after the handshake.
  bit          m_wait[NI];
  int          m_fl[NI];
  int          m_cnt[NI];
  logic [31:0] m_pc[NI];

  bit          e_vld[NI];
  bit          e_fl[NI];
  int          e_cnt[NI];
  logic [31:0] e_pc[NI];

  always #5 clk = ~clk;

  branch_redirect_ctrl dut0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .branch_address(branch_address), .redirect_ready(redirect_ready),
    .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .flush_if_id(fid[0]), .flush_id_ex(fde[0]),
    .ex_squash(sq[0]), .misalign_exc(mis[0]), .taken_count(cnt0)
  );

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .branch_address(branch_address), .redirect_ready(redirect_ready),
    .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .flush_if_id(fid[1]), .flush_id_ex(fde[1]),
    .ex_squash(sq[1]), .misalign_exc(mis[1]), .taken_count(cnt1)
  );

  function automatic int fc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic bit ref_taken();
    if (!ex_valid) return 1'b0;
    if (ex_jump) return 1'b1;
    if (!ex_branch) return 1'b0;
    case (ex_funct3)
      3'b000:  return ex_zero;
      3'b001:  return !ex_zero;
      3'b100:  return ex_lt;
      3'b101:  return !ex_lt;
      3'b110:  return ex_ltu;
      3'b111:  return !ex_ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_ev(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model_step();
    bit tk;
    ev_t e;
    tk = ref_taken();
    for (int i = 0; i < NI; i++) begin
      if (!m_wait[i] && m_fl[i] == 0) begin
        if (tk) begin
          if (branch_address[1:0] == 2'b00) begin
            m_wait[i] = 1'b1;
            m_pc[i]   = branch_address;
            e.mis = 1'b0; e.pc = branch_address;
          end else begin
            e.mis = 1'b1; e.pc = '0;
          end
          push_ev(i, e);
        end
      end else if (m_wait[i]) begin
        if (redirect_ready) begin
          m_wait[i] = 1'b0;
          m_cnt[i]  = (m_cnt[i] + 1 > cmax(i)) ? cmax(i) : m_cnt[i] + 1;
          m_fl[i]   = fc(i) - 1;
        end
      end else begin
        m_fl[i] = m_fl[i] - 1;
      end
    end
  endtask

  task automatic publish();
    for (int i = 0; i < NI; i++) begin
      e_vld[i] = m_wait[i];
      e_fl[i]  = m_wait[i] || (m_fl[i] > 0);
      e_cnt[i] = m_cnt[i];
      e_pc[i]  = m_pc[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_wait[i] = 1'b0; m_fl[i] = 0; m_cnt[i] = 0; m_pc[i] = '0;
    end
    q0.delete();
    q1.delete();
    publish();
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic pop_check(input int i, input bit is_mis, input logic [31:0] pc, input string nm);
    ev_t e;
    int n;
    n = (i == 0) ? q0.size() : q1.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: unexpected event pc=%0h, none expected", nm, i, $time, pc);
    end else begin
      if (i == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (e.mis != is_mis || (!is_mis && e.pc !== pc)) begin
        errors++;
        $display("FAIL %s inst%0d t=%0t: got mis=%0b pc=%0h expected mis=%0b pc=%0h",
                 nm, i, $time, is_mis, pc, e.mis, e.pc);
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_outs"}, i, {26'b0, rv[i], fid[i], fde[i], sq[i], mis[i], 1'b0}, 32'h0);
      chk({nm, "_pc"}, i, rpc[i], 32'h0);
      chk({nm, "_cnt"}, i, (i == 0) ? {16'b0, cnt0} : {30'b0, cnt1}, 32'h0);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pops on handshakes and exception pulses.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("redirect_valid", i, {31'b0, rv[i]}, {31'b0, e_vld[i]});
        chk("flush_if_id", i, {31'b0, fid[i]}, {31'b0, e_fl[i]});
        chk("flush_id_ex", i, {31'b0, fde[i]}, {31'b0, e_fl[i]});
        chk("ex_squash", i, {31'b0, sq[i]}, {31'b0, e_fl[i]});
        chk("redirect_pc", i, rpc[i], e_pc[i]);
        chk("taken_count", i, (i == 0) ? {16'b0, cnt0} : {30'b0, cnt1}, e_cnt[i]);
        if (rv[i] && redirect_ready) pop_check(i, 1'b0, rpc[i], "redirect");
        if (mis[i]) pop_check(i, 1'b1, 32'h0, "misalign");
      end
    end
  end

  task automatic step(input bit v, input bit b, input bit j, input logic [2:0] f3,
                      input bit z, input bit lt, input bit ltu, input logic [31:0] a, input bit rdy);
    @(posedge clk);
    model_step();
    #1;
    publish();
    chk_en         = 1'b1;
    ex_valid       = v;
    ex_branch      = b;
    ex_jump        = j;
    ex_funct3      = f3;
    ex_zero        = z;
    ex_lt          = lt;
    ex_ltu         = ltu;
    branch_address = a;
    redirect_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // beq taken to 24, accepted immediately
    step(1, 1, 0, 3'b000, 1, 0, 0, 32'd24, 1);
    idle(4, 1);
    // bne not taken, funct3=010 never taken
    step(1, 1, 0, 3'b001, 1, 0, 0, 32'h50, 1);
    step(1, 1, 0, 3'b010, 1, 1, 1, 32'h60, 1);
    idle(2, 1);
    // jump to 0x100 held off for three cycles
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h100, 0);
    idle(3, 0);
    idle(3, 1);
    // bltu taken to a misaligned target
    step(1, 1, 0, 3'b110, 0, 0, 1, 32'h22, 1);
    idle(2, 1);
    // second taken branch and a misaligned one while busy
    step(1, 1, 0, 3'b000, 1, 0, 0, 32'h40, 0);
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h80, 0);
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h80, 1);
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h82, 1);
    idle(3, 1);

    // reset while a redirect is pending
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h200, 0);
    idle(1, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk_zero("async_reset");
    model_reset();
    ex_valid = 0; ex_jump = 0; ex_branch = 0; redirect_ready = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 1, 3'b000, 0, 0, 0, 32'h8, 1);
    idle(3, 1);

    // five accepted redirects: saturates the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 3'b000, 0, 0, 0, 32'h1000 + 32'(k * 4), 1);
      idle(3, 1);
    end

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1);
    end

    idle(6, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, 32'(q0.size()), 32'h0);
    chk("scoreboard_drain", 1, 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
